l1_snoop_responder: RTL

- Responder side of the L2→L1 coherence interface for the 8-way L1 data cache.
- Accepts L2-originated commands: n=3 (invalidate) and n=4 (data request / snoop read).
- Looks up the addressed set through the data-cache read port and reports HIT, HITM or NOHIT.
- Writes back a Modified line to L2 when required, then writes the updated MESI state into the cache.
- Sits between the L2 command source and the L1 data-cache array, alongside the processor-side request path.

---
 rtl/l1_snoop_responder_pkg.sv | 52 +++++
 rtl/l1_snoop_responder_way_match.sv | 28 ++
 rtl/l1_snoop_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/l1_snoop_responder_pkg.sv
// Shared types and constants for the L2-to-L1 snoop responder and the
// 8-way L1 data-cache interface it drives.
package l1_snoop_responder_pkg;

  localparam int WAYS           = 8;
  localparam int SET_BITS       = 14;
  localparam int TAG_BITS       = 12;
  localparam int OFFSET_BITS    = 6;
  localparam int WAY_BITS       = $clog2(WAYS);
  localparam int LRU_BITS       = 3;
  localparam int LINE_DATA_BITS = 512;
  localparam int CMD_N_BITS     = 3;
  localparam int ADDR_BITS      = TAG_BITS + SET_BITS + OFFSET_BITS;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'b00,
    SNOOP_HIT   = 2'b01,
    SNOOP_HITM  = 2'b10
  } snoop_result_t;

  localparam logic [CMD_N_BITS-1:0] CMD_L2_INVALIDATE = 3'd3;
  localparam logic [CMD_N_BITS-1:0] CMD_L2_DATA_REQ   = 3'd4;

  typedef struct packed {
    mesi_t                     mesi;
    logic [TAG_BITS-1:0]       tag;
    logic [LRU_BITS-1:0]       lru;
    logic [LINE_DATA_BITS-1:0] data;
  } cache_line_t;

  typedef struct packed {
    logic [CMD_N_BITS-1:0] n;
    logic [ADDR_BITS-1:0]  addr;
  } command_t;

  // Address is laid out as {tag, set, offset}.
  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr);
    return addr[ADDR_BITS-1 -: TAG_BITS];
  endfunction

  function automatic logic [SET_BITS-1:0] addr_set(input logic [ADDR_BITS-1:0] addr);
    return addr[OFFSET_BITS +: SET_BITS];
  endfunction

endpackage

// File: rtl/l1_snoop_responder_way_match.sv
// Combinational valid-tag compare across all ways of one set; when several
// ways match, the lowest way index is reported.
module l1_way_match
  import l1_snoop_responder_pkg::*;
(
  input  mesi_t [WAYS-1:0]                mesi_vec,
  input  logic  [WAYS-1:0][TAG_BITS-1:0]  tag_vec,
  input  logic  [TAG_BITS-1:0]            tag,
  output logic                            hit,
  output logic  [WAY_BITS-1:0]            way,
  output mesi_t                           hit_mesi
);

  // Scan from the top way down so the lowest matching index is the last write.
  always_comb begin
    hit      = 1'b0;
    way      = '0;
    hit_mesi = MESI_I;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (mesi_vec[i] != MESI_I && tag_vec[i] == tag) begin
        hit      = 1'b1;
        way      = i[WAY_BITS-1:0];
        hit_mesi = mesi_vec[i];
      end
    end
  end

endmodule

// File: rtl/l1_snoop_responder.sv
// Responder for L2-originated invalidate / snoop-read commands: reads the
// addressed set, resolves HIT/HITM/NOHIT, writes back Modified data to L2 and
// stores the downgraded MESI state back into the L1 data cache.
module l1_snoop_responder
  import l1_snoop_responder_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  command_t                    cmd,
  output logic                        rd_en,
  output logic [SET_BITS-1:0]         rd_set,
  input  cache_line_t [WAYS-1:0]      rd_lines,
  output logic                        wr_en,
  output logic [SET_BITS-1:0]         wr_set,
  output logic [WAY_BITS-1:0]         wr_way,
  output cache_line_t                 wr_line,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [ADDR_BITS-1:0]        wb_addr,
  output logic                        resp_valid,
  output snoop_result_t               resp
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_COMPARE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_UPDATE    = 3'd4,
    S_RESPOND   = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [CMD_N_BITS-1:0] n_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [SET_BITS-1:0]   set_q;
  logic [WAY_BITS-1:0]   hit_way_q;
  cache_line_t           hit_line_q;
  snoop_result_t         resp_q;

  mesi_t [WAYS-1:0]               way_mesi;
  logic  [WAYS-1:0][TAG_BITS-1:0] way_tag;
  logic                           match_hit;
  logic  [WAY_BITS-1:0]           match_way;
  mesi_t                          match_mesi;
  logic                           cmd_is_snoop;
  logic                           unused_offset;

  // Invalidate drops the line; a snoop read leaves a shared copy behind.
  function automatic mesi_t next_mesi(input logic [CMD_N_BITS-1:0] n);
    return (n == CMD_L2_INVALIDATE) ? MESI_I : MESI_S;
  endfunction

  assign cmd_is_snoop  = (cmd.n == CMD_L2_INVALIDATE) || (cmd.n == CMD_L2_DATA_REQ);
  assign unused_offset = ^cmd.addr[OFFSET_BITS-1:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_split
    assign way_mesi[g] = rd_lines[g].mesi;
    assign way_tag[g]  = rd_lines[g].tag;
  end

  l1_way_match u_way_match (
    .mesi_vec (way_mesi),
    .tag_vec  (way_tag),
    .tag      (tag_q),
    .hit      (match_hit),
    .way      (match_way),
    .hit_mesi (match_mesi)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Command latch (IDLE) and lookup result capture (COMPARE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= '0;
      tag_q      <= '0;
      set_q      <= '0;
      hit_way_q  <= '0;
      hit_line_q <= '0;
      resp_q     <= SNOOP_NOHIT;
    end else begin
      case (state)
        // Accept stage: only snoop commands are kept; others are dropped.
        S_IDLE: begin
          if (cmd_valid && cmd_is_snoop) begin
            n_q   <= cmd.n;
            tag_q <= addr_tag(cmd.addr);
            set_q <= addr_set(cmd.addr);
          end
        end
        // Lookup stage: rd_lines is only trusted in this cycle.
        S_COMPARE: begin
          hit_way_q  <= match_way;
          hit_line_q <= rd_lines[match_way];
          if (!match_hit)                resp_q <= SNOOP_NOHIT;
          else if (match_mesi == MESI_M) resp_q <= SNOOP_HITM;
          else                           resp_q <= SNOOP_HIT;
        end
        default: ;
      endcase
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wb_valid   = 1'b0;
    resp_valid = 1'b0;
    wr_line    = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_is_snoop) state_next = S_READ;
      end
      S_READ: begin
        rd_en      = 1'b1;
        state_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (!match_hit)                state_next = S_RESPOND;
        else if (match_mesi == MESI_M) state_next = S_WRITEBACK;
        else                           state_next = S_UPDATE;
      end
      S_WRITEBACK: begin
        wb_valid = 1'b1;
        if (wb_ready) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        wr_en        = 1'b1;
        wr_line      = hit_line_q;
        wr_line.mesi = next_mesi(n_q);
        state_next   = S_RESPOND;
      end
      S_RESPOND: begin
        resp_valid = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign rd_set  = set_q;
  assign wr_set  = set_q;
  assign wr_way  = hit_way_q;
  assign wb_addr = {tag_q, set_q, {OFFSET_BITS{1'b0}}};
  assign resp    = resp_q;

endmodule
